// File: rtl/mob_pkg.sv
// mob_pkg
// Shared definitions for the motion object scheduler:
//   - byte offsets of the fields inside a 4-byte object record
//   - scan FSM state encoding
//   - hit-queue entry layout {pic, row, x, flip}
package mob_pkg;

  // Byte offsets within an object record
  localparam logic [1:0] BYTE_PIC = 2'd0;
  localparam logic [1:0] BYTE_Y   = 2'd1;
  localparam logic [1:0] BYTE_X   = 2'd2;
  localparam logic [1:0] BYTE_ATR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_Y   = 3'd1,
    S_CMP    = 3'd2,
    S_RD_PIC = 3'd3,
    S_RD_X   = 3'd4,
    S_RD_ATR = 3'd5,
    S_PUSH   = 3'd6,
    S_DONE   = 3'd7
  } mob_state_e;

  typedef struct packed {
    logic [7:0] pic;
    logic [3:0] row;
    logic [7:0] x;
    logic       flip;
  } mob_hit_t;

endpackage

// File: rtl/motion_object_scheduler_if.sv
// motion_object_scheduler_if
// Hit-queue handshake between the scheduler (master) and the line
// renderer that consumes hits (slave).
//   HIT_VALID  master->slave  head entry present
//   HIT_READY  slave->master  consumer accepts head entry this cycle
//   HIT_PIC/HIT_ROW/HIT_X/HIT_FLIP  master->slave  head entry fields
interface motion_object_scheduler_if;
  logic       HIT_VALID;
  logic       HIT_READY;
  logic [7:0] HIT_PIC;
  logic [3:0] HIT_ROW;
  logic [7:0] HIT_X;
  logic       HIT_FLIP;

  modport master (
    output HIT_VALID, HIT_PIC, HIT_ROW, HIT_X, HIT_FLIP,
    input  HIT_READY
  );

  modport slave (
    input  HIT_VALID, HIT_PIC, HIT_ROW, HIT_X, HIT_FLIP,
    output HIT_READY
  );
endinterface

// File: rtl/mob_hit_fifo.sv
// mob_hit_fifo
// Small synchronous FIFO holding hit entries.
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and entry (ignored when full unless popping)
//   pop        read request (ignored when empty)
//   flush      empties the queue; overrides push and pop
//   dout       head entry, zero when empty
//   full, empty  status
module mob_hit_fifo
  import mob_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  mob_hit_t din,
  output mob_hit_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  mob_hit_t        mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  // Pointer wrap that also works for non-power-of-two depths
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(FIFO_DEPTH));
  assign pop_ok_s  = pop & ~empty;
  // A full queue still accepts a write when the head leaves in the same cycle
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = empty ? '0 : mem_r[rd_ptr_r];

  // Entry storage; contents are only observable while counted as valid
  always_ff @(posedge clk) begin
    if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_r <= count_r + CW'(1);
      end else if (!push_ok_s && pop_ok_s) begin
        count_r <= count_r - CW'(1);
      end
    end
  end

endmodule

// File: rtl/motion_object_scheduler.sv
// motion_object_scheduler
// Per-line object scan: walks the object RAM, compares each object's Y
// against the line being prepared and queues {pic,row,x,flip} for hits.
//   CLK, RESET      clock, asynchronous active-high reset
//   HSTART, VLINE   line start pulse and line number (sampled on HSTART)
//   MOB_A, MOB_RD   object RAM byte address {index,byte} and read strobe
//   MOB_D           object RAM data, valid the cycle after MOB_RD
//   hit             hit-queue handshake (master side)
//   BUSY            scan in progress
//   LATE            pulse: HSTART arrived while a scan was still running
module motion_object_scheduler
  import mob_pkg::*;
#(
  parameter int NUM_OBJ    = 32,
  parameter int OBJ_HEIGHT = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_HITS   = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      HSTART,
  input  logic [7:0]                VLINE,
  output logic [6:0]                MOB_A,
  output logic                      MOB_RD,
  input  logic [7:0]                MOB_D,
  motion_object_scheduler_if.master hit,
  output logic                      BUSY,
  output logic                      LATE
);

  localparam int HW = $clog2(MAX_HITS + 1);

  mob_state_e    state_r, state_nx;
  logic          phase_r, phase_nx;     // 0: address cycle, 1: capture cycle
  logic [4:0]    idx_r, idx_nx;
  logic [HW-1:0] hits_r, hits_nx;
  logic [7:0]    vline_r, vline_nx;
  logic [3:0]    row_r, row_nx;
  logic [7:0]    pic_r, pic_nx;
  logic [7:0]    x_r, x_nx;
  logic          flip_r, flip_nx;
  logic          mob_rd_r, mob_rd_nx;
  logic [6:0]    mob_a_r, mob_a_nx;
  logic          busy_r;
  logic          late_r;

  logic [7:0]    row_s;
  logic          is_hit_s;
  logic          last_obj_s;
  logic          push_s;
  logic          pop_s;
  logic          flush_s;
  logic          full_s;
  logic          empty_s;
  mob_hit_t      entry_s;
  mob_hit_t      head_s;

  // Modulo-256 distance from the object's top line; wraps objects near Y=255
  assign row_s      = vline_r - MOB_D;
  assign is_hit_s   = ({1'b0, row_s} < 9'(OBJ_HEIGHT));
  assign last_obj_s = (idx_r == 5'(NUM_OBJ - 1));

  assign pop_s   = ~empty_s & hit.HIT_READY & ~HSTART;
  assign flush_s = HSTART & (state_r != S_IDLE);
  assign entry_s = '{pic: pic_r, row: row_r, x: x_r, flip: flip_r};

  mob_hit_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (entry_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign hit.HIT_VALID = ~empty_s;
  assign hit.HIT_PIC   = head_s.pic;
  assign hit.HIT_ROW   = head_s.row;
  assign hit.HIT_X     = head_s.x;
  assign hit.HIT_FLIP  = head_s.flip;

  assign MOB_A  = mob_a_r;
  assign MOB_RD = mob_rd_r;
  assign BUSY   = busy_r;
  assign LATE   = late_r;

  // Scan FSM next state and capture-register updates
  always_comb begin
    state_nx = state_r;
    phase_nx = phase_r;
    idx_nx   = idx_r;
    hits_nx  = hits_r;
    vline_nx = vline_r;
    row_nx   = row_r;
    pic_nx   = pic_r;
    x_nx     = x_r;
    flip_nx  = flip_r;
    push_s   = 1'b0;
    if (HSTART) begin
      // New line always wins, even over a pending push or pop
      vline_nx = VLINE;
      idx_nx   = 5'd0;
      hits_nx  = '0;
      phase_nx = 1'b0;
      state_nx = S_RD_Y;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_nx = S_IDLE;
        end
        S_RD_Y: begin
          state_nx = S_CMP;
        end
        S_CMP: begin
          if (is_hit_s) begin
            row_nx   = row_s[3:0];
            phase_nx = 1'b0;
            state_nx = S_RD_PIC;
          end else if (last_obj_s) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx_r + 5'd1;
            state_nx = S_RD_Y;
          end
        end
        S_RD_PIC: begin
          if (!phase_r) begin
            phase_nx = 1'b1;
          end else begin
            pic_nx   = MOB_D;
            phase_nx = 1'b0;
            state_nx = S_RD_X;
          end
        end
        S_RD_X: begin
          if (!phase_r) begin
            phase_nx = 1'b1;
          end else begin
            x_nx     = MOB_D;
            phase_nx = 1'b0;
            state_nx = S_RD_ATR;
          end
        end
        S_RD_ATR: begin
          if (!phase_r) begin
            phase_nx = 1'b1;
          end else begin
            flip_nx  = MOB_D[7];
            phase_nx = 1'b0;
            state_nx = S_PUSH;
          end
        end
        S_PUSH: begin
          if (!full_s || pop_s) begin
            push_s  = 1'b1;
            hits_nx = hits_r + HW'(1);
            if ((hits_r + HW'(1)) == HW'(MAX_HITS)) begin
              state_nx = S_DONE;
            end else if (last_obj_s) begin
              state_nx = S_DONE;
            end else begin
              idx_nx   = idx_r + 5'd1;
              state_nx = S_RD_Y;
            end
          end else begin
            state_nx = S_PUSH;
          end
        end
        S_DONE: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // RAM strobe/address for the state being entered, so both come from flops
  always_comb begin
    mob_rd_nx = 1'b0;
    mob_a_nx  = 7'd0;
    case (state_nx)
      S_RD_Y: begin
        mob_rd_nx = 1'b1;
        mob_a_nx  = {idx_nx, BYTE_Y};
      end
      S_RD_PIC: begin
        if (!phase_nx) begin
          mob_rd_nx = 1'b1;
          mob_a_nx  = {idx_nx, BYTE_PIC};
        end else begin
          mob_rd_nx = 1'b0;
          mob_a_nx  = 7'd0;
        end
      end
      S_RD_X: begin
        if (!phase_nx) begin
          mob_rd_nx = 1'b1;
          mob_a_nx  = {idx_nx, BYTE_X};
        end else begin
          mob_rd_nx = 1'b0;
          mob_a_nx  = 7'd0;
        end
      end
      S_RD_ATR: begin
        if (!phase_nx) begin
          mob_rd_nx = 1'b1;
          mob_a_nx  = {idx_nx, BYTE_ATR};
        end else begin
          mob_rd_nx = 1'b0;
          mob_a_nx  = 7'd0;
        end
      end
      default: begin
        mob_rd_nx = 1'b0;
        mob_a_nx  = 7'd0;
      end
    endcase
  end

  // State, capture registers and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r  <= S_IDLE;
      phase_r  <= 1'b0;
      idx_r    <= 5'd0;
      hits_r   <= '0;
      vline_r  <= 8'd0;
      row_r    <= 4'd0;
      pic_r    <= 8'd0;
      x_r      <= 8'd0;
      flip_r   <= 1'b0;
      mob_rd_r <= 1'b0;
      mob_a_r  <= 7'd0;
      busy_r   <= 1'b0;
      late_r   <= 1'b0;
    end else begin
      state_r  <= state_nx;
      phase_r  <= phase_nx;
      idx_r    <= idx_nx;
      hits_r   <= hits_nx;
      vline_r  <= vline_nx;
      row_r    <= row_nx;
      pic_r    <= pic_nx;
      x_r      <= x_nx;
      flip_r   <= flip_nx;
      mob_rd_r <= mob_rd_nx;
      mob_a_r  <= mob_a_nx;
      busy_r   <= (state_nx != S_IDLE);
      late_r   <= HSTART & (state_r != S_IDLE);
    end
  end

endmodule

// File: tb/tb_motion_object_scheduler.sv
// Directed self-checking bench for motion_object_scheduler with a
// behavioural object RAM (one-cycle read latency).
module tb_motion_object_scheduler;
  import mob_pkg::*;

  logic       clk;
  logic       rst;
  logic       hstart;
  logic [7:0] vline;
  logic [6:0] mob_a;
  logic       mob_rd;
  logic [7:0] mob_d;
  logic       busy;
  logic       late;

  motion_object_scheduler_if hit_bus();

  motion_object_scheduler dut (
    .CLK    (clk),
    .RESET  (rst),
    .HSTART (hstart),
    .VLINE  (vline),
    .MOB_A  (mob_a),
    .MOB_RD (mob_rd),
    .MOB_D  (mob_d),
    .hit    (hit_bus),
    .BUSY   (busy),
    .LATE   (late)
  );

  logic [7:0]  ram [128];
  logic [20:0] got_q [$];
  int          errors;
  int          checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Object RAM: data appears the cycle after the read strobe
  initial mob_d = 8'd0;
  always @(posedge clk) begin
    if (mob_rd) mob_d <= ram[mob_a];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 32; i++) begin
      ram[i*4+0] = 8'h00;
      ram[i*4+1] = 8'hF0;
      ram[i*4+2] = 8'h00;
      ram[i*4+3] = 8'h00;
    end
  endtask

  task automatic set_obj(input int i, input logic [7:0] pic, input logic [7:0] y,
                         input logic [7:0] x, input logic [7:0] atr);
    ram[i*4+0] = pic;
    ram[i*4+1] = y;
    ram[i*4+2] = x;
    ram[i*4+3] = atr;
  endtask

  // Leaves the bench #1 after the edge that sampled HSTART
  task automatic pulse_hstart(input logic [7:0] v);
    hstart = 1'b1;
    vline  = v;
    step();
    hstart = 1'b0;
  endtask

  // Records every popped entry until the scan ends and the queue drains
  task automatic scan_collect(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    got_q.delete();
    while (!done && n < budget) begin
      if (hit_bus.HIT_VALID && hit_bus.HIT_READY)
        got_q.push_back({hit_bus.HIT_PIC, hit_bus.HIT_ROW, hit_bus.HIT_X, hit_bus.HIT_FLIP});
      if (!busy && !hit_bus.HIT_VALID) begin
        done = 1'b1;
      end else begin
        step();
        n++;
      end
    end
    check_eq("scan_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int  n;
    bit  seen;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    hstart = 1'b0;
    vline  = 8'd0;
    hit_bus.HIT_READY = 1'b0;
    clear_ram();
    step();
    step();

    // Reset state
    check_eq("rst_mob_rd", {31'd0, mob_rd}, 32'd0);
    check_eq("rst_mob_a", {25'd0, mob_a}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_late", {31'd0, late}, 32'd0);
    check_eq("rst_valid", {31'd0, hit_bus.HIT_VALID}, 32'd0);
    check_eq("rst_hit", {11'd0, hit_bus.HIT_PIC, hit_bus.HIT_ROW, hit_bus.HIT_X, hit_bus.HIT_FLIP}, 32'd0);
    rst = 1'b0;
    step();

    // All objects miss: 32 x 2 scan cycles + DONE
    hit_bus.HIT_READY = 1'b1;
    pulse_hstart(8'h40);
    check_eq("miss_first_a", {25'd0, mob_a}, 32'h01);
    check_eq("miss_first_rd", {31'd0, mob_rd}, 32'd1);
    n = 0;
    seen = 1'b0;
    while (busy && n < 200) begin
      if (hit_bus.HIT_VALID) seen = 1'b1;
      n++;
      step();
    end
    check_eq("miss_busy_cycles", n, 32'd65);
    check_eq("miss_no_valid", {31'd0, seen}, 32'd0);

    // Single hit on object 5, row 6, flipped
    set_obj(5, 8'h12, 8'h3A, 8'h80, 8'h80);
    pulse_hstart(8'h40);
    scan_collect(300);
    check_eq("one_hit_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("one_hit_entry", {11'd0, got_q[0]}, {11'd0, 8'h12, 4'd6, 8'h80, 1'b1});

    // Y wrap: 0x02 - 0xF8 = 0x0A
    clear_ram();
    set_obj(0, 8'h55, 8'hF8, 8'h21, 8'h00);
    pulse_hstart(8'h02);
    scan_collect(300);
    check_eq("wrap_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("wrap_entry", {11'd0, got_q[0]}, {11'd0, 8'h55, 4'd10, 8'h21, 1'b0});

    // Height boundary: row 16 misses, row 15 hits
    clear_ram();
    set_obj(3, 8'h33, 8'h30, 8'h77, 8'h80);
    set_obj(4, 8'h44, 8'h31, 8'h99, 8'h7F);
    pulse_hstart(8'h40);
    scan_collect(300);
    check_eq("edge_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("edge_entry", {11'd0, got_q[0]}, {11'd0, 8'h44, 4'd15, 8'h99, 1'b0});

    // Ten hits with back-pressure: queue fills, FSM stalls, MAX_HITS ends it
    clear_ram();
    for (int i = 0; i < 10; i++)
      set_obj(i, 8'h20 + 8'(i), 8'h40, 8'(i * 8), {i[0], 7'd0});
    hit_bus.HIT_READY = 1'b0;
    pulse_hstart(8'h40);
    repeat (80) step();
    check_eq("stall_state", {29'd0, dut.state_r}, {29'd0, S_PUSH});
    check_eq("stall_no_rd", {31'd0, mob_rd}, 32'd0);
    check_eq("stall_valid", {31'd0, hit_bus.HIT_VALID}, 32'd1);
    check_eq("stall_head_pic", {24'd0, hit_bus.HIT_PIC}, 32'h20);
    step();
    check_eq("stall_head_hold", {24'd0, hit_bus.HIT_PIC}, 32'h20);
    hit_bus.HIT_READY = 1'b1;
    scan_collect(600);
    check_eq("max_hits_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size())
        check_eq($sformatf("order_%0d", i), {11'd0, got_q[i]},
                 {11'd0, 8'h20 + 8'(i), 4'd0, 8'(i * 8), i[0]});
    end

    // HSTART during a push stall: LATE, flush, restart at object 0
    hit_bus.HIT_READY = 1'b0;
    pulse_hstart(8'h40);
    repeat (80) step();
    check_eq("late_pre_valid", {31'd0, hit_bus.HIT_VALID}, 32'd1);
    pulse_hstart(8'h40);
    check_eq("late_pulse", {31'd0, late}, 32'd1);
    check_eq("late_flush", {31'd0, hit_bus.HIT_VALID}, 32'd0);
    check_eq("late_restart_a", {25'd0, mob_a}, 32'h01);
    check_eq("late_restart_rd", {31'd0, mob_rd}, 32'd1);
    step();
    check_eq("late_one_cycle", {31'd0, late}, 32'd0);
    hit_bus.HIT_READY = 1'b1;
    scan_collect(600);
    check_eq("rescan_count", got_q.size(), 32'd8);
    if (got_q.size() > 0) check_eq("rescan_first", {11'd0, got_q[0]}, {11'd0, 8'h20, 4'd0, 8'h00, 1'b0});

    // Reset in the middle of RD_X
    pulse_hstart(8'h40);
    n = 0;
    while (!(mob_rd && mob_a == 7'h02) && n < 50) begin
      step();
      n++;
    end
    check_eq("rdx_reached", {31'd0, (n < 50)}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rd", {31'd0, mob_rd}, 32'd0);
    check_eq("mid_rst_a", {25'd0, mob_a}, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, hit_bus.HIT_VALID}, 32'd0);
    step();
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mob_rd || busy) seen = 1'b1;
      step();
    end
    check_eq("post_rst_quiet", {31'd0, seen}, 32'd0);
    pulse_hstart(8'h40);
    check_eq("post_rst_start_a", {25'd0, mob_a}, 32'h01);
    check_eq("post_rst_start_rd", {31'd0, mob_rd}, 32'd1);
    scan_collect(600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
